// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, hazard/EX redirect inputs, decoder handshake, IF/ID outputs.
// Latency: n/a (wires only).
// Backpressure: stall is carried here from the hazard unit; no valid/ready pairs are involved.
interface fetch_stage_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            stall;
    logic            ex_branch_taken;
    logic [PC_W-1:0] ex_branch_target;
    logic            jmp;
    logic            select_pc_src;
    logic            update_rr;
    logic [15:0]     id_instr;
    logic [3:0]      id_opcode;
    logic [2:0]      id_func;
    logic [PC_W-1:0] id_pc;
    logic            id_valid;
    logic [PC_W-1:0] rr;

    // Fetch stage side
    modport master (
        output imem_addr, id_instr, id_opcode, id_func, id_pc, id_valid, rr,
        input  imem_rdata, stall, ex_branch_taken, ex_branch_target,
               jmp, select_pc_src, update_rr
    );

    // Environment side (memory, hazard unit, EX, decoder)
    modport slave (
        input  imem_addr, id_instr, id_opcode, id_func, id_pc, id_valid, rr,
        output imem_rdata, stall, ex_branch_taken, ex_branch_target,
               jmp, select_pc_src, update_rr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: owns pc and rr, inserts bubbles on jump/call/ret and taken branches.
// Latency: fetch to ID is 1 cycle; redirects cost 1 bubble.
// Backpressure: stall freezes pc, IF/ID and rr; a taken EX branch overrides stall.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.master bus
);
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] rr_q, rr_nxt;
    logic [PC_W-1:0] id_pc_q, id_pc_nxt;
    logic [15:0]     id_instr_q, id_instr_nxt;
    logic            id_valid_q, id_valid_nxt;

    logic [PC_W-1:0] jump_target;
    logic            redirect_jmp;
    logic            redirect_ret;
    logic            rr_wr;

    // Decoder controls only count when ID holds a real instruction
    assign redirect_jmp = id_valid_q & bus.select_pc_src & bus.jmp;
    assign redirect_ret = id_valid_q & bus.select_pc_src & ~bus.jmp;
    assign rr_wr        = id_valid_q & bus.update_rr & ~bus.stall & ~bus.ex_branch_taken;
    assign jump_target  = id_pc_q + {{(PC_W-9){id_instr_q[11]}}, id_instr_q[11:3]};

    // Next-state selection: branch > stall > jump/call > ret > sequential fetch
    always_comb begin
        pc_nxt       = pc;
        id_pc_nxt    = id_pc_q;
        id_instr_nxt = id_instr_q;
        id_valid_nxt = id_valid_q;
        rr_nxt       = rr_q;
        if (bus.ex_branch_taken) begin
            pc_nxt       = bus.ex_branch_target;
            id_instr_nxt = 16'h0000;
            id_valid_nxt = 1'b0;
        end else if (bus.stall) begin
            pc_nxt = pc;
        end else if (redirect_jmp) begin
            pc_nxt       = jump_target;
            id_instr_nxt = 16'h0000;
            id_valid_nxt = 1'b0;
        end else if (redirect_ret) begin
            pc_nxt       = rr_q;
            id_instr_nxt = 16'h0000;
            id_valid_nxt = 1'b0;
        end else begin
            pc_nxt       = pc + PC_W'(1);
            id_instr_nxt = bus.imem_rdata;
            id_pc_nxt    = pc;
            id_valid_nxt = 1'b1;
        end
        if (rr_wr) begin
            rr_nxt = id_pc_q + PC_W'(1);
        end
    end

    // State registers; reset discards any in-flight redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            rr_q       <= '0;
            id_pc_q    <= '0;
            id_instr_q <= 16'h0000;
            id_valid_q <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            rr_q       <= rr_nxt;
            id_pc_q    <= id_pc_nxt;
            id_instr_q <= id_instr_nxt;
            id_valid_q <= id_valid_nxt;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.rr        = rr_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_opcode = id_instr_q[15:12];
    assign bus.id_func   = id_instr_q[2:0];
    assign bus.id_pc     = id_pc_q;
    assign bus.id_valid  = id_valid_q;
endmodule
